// File: rtl/shortcut_fm_streamer_pkg.sv
// Shared types and width helpers for the shortcut feature-map streamer.
package shortcut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int clog2_min1(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    function automatic int cw_of(input int ic);
        return clog2_min1(ic);
    endfunction

    function automatic int rw_of(input int fs);
        return clog2_min1(fs);
    endfunction

    function automatic int aw_of(input int ic, input int fs, input int sp);
        return clog2_min1(ic * fs * fs / sp);
    endfunction

endpackage

// File: rtl/shortcut_fm_streamer_fifo.sv
// Two-entry skid FIFO; head visible the cycle after push, no bypass.
// Backpressure: caller keeps push below capacity; a pop in the same cycle frees a slot.
module stream_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [1:0]   occ_o,
    output logic         head_vld_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   occ_q;
    logic         pop_ok;

    assign pop_ok     = pop_i && (occ_q != 2'd0);
    assign occ_o      = occ_q;
    assign head_vld_o = (occ_q != 2'd0);
    assign head_o     = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/shortcut_fm_streamer.sv
// Streams a CHW feature buffer from SRAM as tagged SP-pixel beats; start-to-first-beat 2 cycles.
// Reads are issued only while FIFO occupancy plus the in-flight read leaves room, so stalls never drop data.
module shortcut_fm_streamer
    import shortcut_pkg::*;
#(
    parameter  int N                = 16,
    parameter  int IN_CHANNELS      = 24,
    parameter  int FEATURE_SIZE     = 28,
    parameter  int SPATIAL_PARALLEL = 2,
    localparam int SP = SPATIAL_PARALLEL,
    localparam int FS = FEATURE_SIZE,
    localparam int CW = cw_of(IN_CHANNELS),
    localparam int RW = rw_of(FEATURE_SIZE),
    localparam int AW = aw_of(IN_CHANNELS, FEATURE_SIZE, SPATIAL_PARALLEL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               mem_rd_en,
    output logic [AW-1:0]      mem_rd_addr,
    input  logic [SP*N-1:0]    mem_rd_data,
    input  logic               out_ready,
    output logic [SP*N-1:0]    data_out,
    output logic [SP*CW-1:0]   channel_out,
    output logic [SP-1:0]      valid_out,
    output logic [RW-1:0]      row_idx,
    output logic [RW-1:0]      col_idx,
    output logic               busy,
    output logic               done,
    output logic [AW:0]        beats_sent
);

    typedef struct packed {
        logic [SP*N-1:0] data;
        logic [CW-1:0]   c;
        logic [RW-1:0]   row;
        logic [RW-1:0]   col;
    } beat_t;

    localparam logic [CW-1:0] C_LAST   = CW'(IN_CHANNELS - 1);
    localparam logic [RW-1:0] COL_LAST = RW'(FS - SP);
    localparam logic [RW-1:0] ROW_LAST = RW'(FS - 1);
    localparam logic [RW-1:0] COL_STEP = RW'(SP);

    state_e        state_q, state_d;
    logic [CW-1:0] c_q, c_d, tag_c_q;
    logic [RW-1:0] row_q, row_d, col_q, col_d, tag_row_q, tag_col_q;
    logic          rd_vld_q;
    logic [AW:0]   beats_q;
    logic [1:0]    occ;
    logic [2:0]    credit_sum;
    logic          head_vld, pop, credit_ok, last_rd, fifo_idle, start_ok;
    beat_t         push_beat, head;

    assign pop        = head_vld && out_ready;
    assign start_ok   = (state_q == ST_IDLE) && start;
    assign last_rd    = (c_q == C_LAST) && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign fifo_idle  = (occ == 2'd0) && !rd_vld_q;
    // Entries already held or on their way, minus the one leaving this cycle.
    assign credit_sum = {1'b0, occ} + {2'b0, rd_vld_q} - {2'b0, pop};
    assign credit_ok  = (credit_sum < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (mem_rd_en && last_rd) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_idle) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                busy      = 1'b1;
                mem_rd_en = credit_ok;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                done = fifo_idle;
            end
            default: ;
        endcase
    end

    // Channel innermost, then column group, then row.
    always_comb begin
        c_d   = c_q;
        row_d = row_q;
        col_d = col_q;
        if (start_ok) begin
            c_d   = '0;
            row_d = '0;
            col_d = '0;
        end else if (mem_rd_en) begin
            if (c_q != C_LAST) begin
                c_d = c_q + CW'(1);
            end else begin
                c_d = '0;
                if (col_q != COL_LAST) begin
                    col_d = col_q + COL_STEP;
                end else begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            rd_vld_q  <= 1'b0;
            tag_c_q   <= '0;
            tag_row_q <= '0;
            tag_col_q <= '0;
            beats_q   <= '0;
        end else begin
            c_q      <= c_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rd_vld_q <= mem_rd_en;
            if (mem_rd_en) begin
                tag_c_q   <= c_q;
                tag_row_q <= row_q;
                tag_col_q <= col_q;
            end
            if (start_ok) begin
                beats_q <= '0;
            end else if (pop) begin
                beats_q <= beats_q + (AW+1)'(1);
            end
        end
    end

    assign mem_rd_addr = AW'(int'(c_q) * (FS * FS / SP) + int'(row_q) * (FS / SP) + int'(col_q) / SP);

    assign push_beat = '{data: mem_rd_data, c: tag_c_q, row: tag_row_q, col: tag_col_q};

    stream_skid_fifo #(.W($bits(beat_t))) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rd_vld_q),
        .din_i      (push_beat),
        .pop_i      (pop),
        .occ_o      (occ),
        .head_vld_o (head_vld),
        .head_o     (head)
    );

    assign data_out    = head.data;
    assign channel_out = {SP{head.c}};
    assign valid_out   = {SP{head_vld}};
    assign row_idx     = head.row;
    assign col_idx     = head.col;
    assign beats_sent  = beats_q;

endmodule

// File: tb/tb_shortcut_fm_streamer.sv
// Scoreboard bench: default-size streamer under full-rate, stalled, random and reset traffic, plus a 4x4x3 instance.
module tb_shortcut_fm_streamer;

    localparam int T_A = 24 * 28 * 28 / 2;
    localparam int T_B = 3 * 4 * 4 / 2;

    logic clk, rst;
    int   total = 0;
    int   bad   = 0;

    // default instance
    logic        start, out_ready, mem_rd_en, busy, done;
    logic [13:0] mem_rd_addr;
    logic [31:0] mem_rd_data, data_out;
    logic [9:0]  channel_out;
    logic [1:0]  valid_out;
    logic [4:0]  row_idx, col_idx;
    logic [14:0] beats_sent;

    // small instance
    logic        start_b, ready_b, rd_en_b, busy_b, done_b;
    logic [4:0]  addr_b;
    logic [31:0] rdata_b, data_b;
    logic [3:0]  chan_b;
    logic [1:0]  valid_b, row_b, col_b;
    logic [5:0]  bsent_b;

    shortcut_fm_streamer dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_ready(out_ready), .data_out(data_out), .channel_out(channel_out),
        .valid_out(valid_out), .row_idx(row_idx), .col_idx(col_idx),
        .busy(busy), .done(done), .beats_sent(beats_sent)
    );

    shortcut_fm_streamer #(.IN_CHANNELS(3), .FEATURE_SIZE(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .mem_rd_en(rd_en_b), .mem_rd_addr(addr_b), .mem_rd_data(rdata_b),
        .out_ready(ready_b), .data_out(data_b), .channel_out(chan_b),
        .valid_out(valid_b), .row_idx(row_b), .col_idx(col_b),
        .busy(busy_b), .done(done_b), .beats_sent(bsent_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: word w holds w, returned one cycle after the strobe.
    initial mem_rd_data = '0;
    initial rdata_b     = '0;
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= 32'(mem_rd_addr);
    always @(posedge clk) if (rd_en_b)   rdata_b     <= 32'(addr_b);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Beat idx of a frame: channel innermost, then column pair, then row.
    function automatic void beat_model(input int idx, input int ic, input int fs,
                                       output int c, output int r, output int co, output int a);
        int grp;
        grp = idx / ic;
        c   = idx % ic;
        r   = grp / (fs / 2);
        co  = (grp % (fs / 2)) * 2;
        a   = (c * fs * fs + r * fs + co) / 2;
    endfunction

    int   exp_q[$];
    int   rd_idx, rd_cnt, acc_cnt, done_cnt, b_idx, b_done;
    bit   stall_v;
    logic [63:0] stall_pl, pay_now;

    assign pay_now = 64'({data_out, channel_out, valid_out, row_idx, col_idx});

    always @(negedge clk) begin
        int idx, c, r, co, a;
        if (rst) begin
            exp_q.delete();
            rd_idx = 0; rd_cnt = 0; acc_cnt = 0; done_cnt = 0; stall_v = 0;
        end else begin
            if (start && !busy) begin
                exp_q.delete();
                rd_idx = 0; rd_cnt = 0; acc_cnt = 0; done_cnt = 0;
            end
            if (stall_v && valid_out[0]) check("stall_stable", pay_now, stall_pl);
            stall_v  = valid_out[0] && !out_ready;
            stall_pl = pay_now;
            if (mem_rd_en) begin
                exp_q.push_back(rd_idx);
                rd_idx++;
                rd_cnt++;
            end
            if (valid_out[0] && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(acc_cnt), 64'(-1));
                end else begin
                    idx = exp_q.pop_front();
                    beat_model(idx, 24, 28, c, r, co, a);
                    check("beat", pay_now,
                          64'({32'(a), 5'(c), 5'(c), 2'b11, 5'(r), 5'(co)}));
                    if (idx == 24)
                        check("beat24_tags", 64'({row_idx, col_idx, channel_out[4:0]}),
                              64'({5'd0, 5'd2, 5'd0}));
                end
                acc_cnt++;
            end
            if (done) begin
                done_cnt++;
                check("frame_beats", 64'(acc_cnt), 64'(T_A));
                check("beats_sent", 64'(beats_sent), 64'(T_A));
                check("queue_empty", 64'(exp_q.size()), 64'(0));
            end
        end
    end

    always @(negedge clk) begin
        int c, r, co, a;
        if (rst) begin
            b_idx = 0; b_done = 0;
        end else begin
            if (start_b && !busy_b) begin
                b_idx = 0; b_done = 0;
            end
            if (valid_b[0] && ready_b) begin
                beat_model(b_idx, 3, 4, c, r, co, a);
                check("b_beat", 64'({data_b, chan_b, valid_b, row_b, col_b}),
                      64'({32'(a), 2'(c), 2'(c), 2'b11, 2'(r), 2'(co)}));
                if (b_idx == T_B - 1)
                    check("b_last_tags", 64'({row_b, col_b, chan_b[1:0]}), 64'({2'd3, 2'd2, 2'd2}));
                b_idx++;
            end
            if (done_b) begin
                b_done++;
                check("b_frame_beats", 64'(b_idx), 64'(T_B));
                check("b_beats_sent", 64'(bsent_b), 64'(T_B));
            end
        end
    end

    bit rnd_mode = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic chk_reset_outputs();
        check("rst_payload", pay_now, 64'(0));
        check("rst_ctrl", 64'({mem_rd_en, mem_rd_addr, busy, done, beats_sent}), 64'(0));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check("done_seen", 64'(done_cnt != 0), 64'(1));
        repeat (4) step();
        check("done_once", 64'(done_cnt), 64'(1));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; start_b = 1'b0; ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        step();

        // full rate, both instances
        start = 1'b1; start_b = 1'b1;
        step();
        start = 1'b0; start_b = 1'b0;
        wait_done(12000);
        check("b_done_once", 64'(b_done), 64'(1));

        // stall from first beat, then random ready with a stray start mid-frame
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!valid_out[0] && n < 10) begin step(); n++; end
        check("first_beat_seen", 64'(valid_out[0]), 64'(1));
        repeat (20) step();
        check("stall_reads_le2", 64'(rd_cnt <= 2), 64'(1));
        rnd_mode = 1;
        n = 0;
        while (acc_cnt < 3000 && n < 20000) begin step(); n++; end
        check("mid_reached", 64'(acc_cnt >= 3000), 64'(1));
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(30000);
        rnd_mode = 0;
        out_ready = 1'b1;

        // reset mid-frame, then a fresh frame
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (acc_cnt < 1000 && n < 3000) begin step(); n++; end
        check("beat1000_reached", 64'(acc_cnt), 64'(1000));
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) step();
        rst = 1'b0;
        repeat (6) step();
        check("no_done_after_rst", 64'(done_cnt), 64'(0));
        check("idle_after_rst", 64'(busy), 64'(0));
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(12000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
